// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO, paced by the shared 16x tick.
// TxD is registered and idles high so it can drive the pin directly.
module uart_tx #(
  parameter int FIFO_AW = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_tick_16x,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       ready,
  output logic       busy
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [3:0] {
    IDLE,
    START,
    BIT_0,
    BIT_1,
    BIT_2,
    BIT_3,
    BIT_4,
    BIT_5,
    BIT_6,
    BIT_7,
    STOP
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  state_t     state;
  logic [3:0] tick_cnt;
  logic [7:0] shift;

  logic push;
  logic pop;
  logic last_tick;
  logic in_data_bit;

  // count never exceeds DEPTH, so its MSB alone marks the FIFO as full
  assign ready       = ~count[FIFO_AW];
  assign push        = TxD_start & ready;
  assign pop         = (state == IDLE) & uart_tick_16x & (count != '0);
  assign last_tick   = uart_tick_16x & (tick_cnt == 4'd15);
  assign in_data_bit = (state >= BIT_0) & (state <= BIT_7);
  assign busy        = (count != '0) | (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= TxD_data;
  end

  // Shift register holds the byte in flight; bit 0 is always the bit on the wire
  always_ff @(posedge clock) begin
    if (pop) begin
      shift <= mem[rd_ptr];
    end else if (last_tick && in_data_bit) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= 4'd0;
      TxD      <= 1'b1;
    end else if (state == IDLE) begin
      if (pop) begin
        state    <= START;
        tick_cnt <= 4'd0;
        TxD      <= 1'b0;
      end
    end else if (uart_tick_16x) begin
      tick_cnt <= tick_cnt + 4'd1;
      if (tick_cnt == 4'd15) begin
        case (state)
          START: begin
            state <= BIT_0;
            TxD   <= shift[0];
          end
          BIT_7: begin
            state <= STOP;
            TxD   <= 1'b1;
          end
          STOP: begin
            state <= IDLE;
            TxD   <= 1'b1;
          end
          default: begin
            // shift[1] becomes shift[0] on this same edge
            state <= state_t'(state + 4'd1);
            TxD   <= shift[1];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table vectors, directed corner sequences and random traffic
// checked every cycle against a queue-based frame model plus a loopback receiver.
module tb_uart_tx;

  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       uart_tick_16x;
  logic       TxD_start;
  logic [7:0] TxD_data;
  logic       TxD;
  logic       ready;
  logic       busy;

  uart_tx #(.FIFO_AW(FIFO_AW)) dut (
    .clock(clock),
    .reset(reset),
    .uart_tick_16x(uart_tick_16x),
    .TxD_start(TxD_start),
    .TxD_data(TxD_data),
    .TxD(TxD),
    .ready(ready),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model: queued bytes, plus the frame in flight tracked as ticks since its start
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  bit         m_active = 1'b0;
  int         m_tcnt = 0;
  logic [7:0] m_cur = 8'h00;

  // loopback receiver
  logic [7:0] rx_q[$];
  logic       rx_bits[$];
  int         start_ticks[$];
  bit         rx_active = 1'b0;
  int         rx_tick = 0;
  logic [7:0] rx_byte = 8'h00;
  int         tick_num = 0;

  typedef struct {
    logic       start;
    logic [7:0] data;
    logic       tick;
    logic       exp_txd;
    logic       exp_ready;
    logic       exp_busy;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_txd();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_tcnt / 16;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit can_push;
    if (reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_tcnt   = 0;
      return;
    end
    can_push = (m_q.size() < DEPTH);
    if (m_active) begin
      if (uart_tick_16x) begin
        m_tcnt++;
        if (m_tcnt == 160) m_active = 1'b0;
      end
    end else if (uart_tick_16x && m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      m_sent.push_back(m_cur);
      m_active = 1'b1;
      m_tcnt   = 0;
    end
    if (TxD_start && can_push) m_q.push_back(TxD_data);
  endtask

  task automatic rx_update();
    int idx;
    if (reset) begin
      rx_active = 1'b0;
      return;
    end
    if (uart_tick_16x) begin
      tick_num++;
      if (rx_active) begin
        rx_tick++;
        if (rx_tick % 16 == 8) begin
          idx = rx_tick / 16;
          rx_bits.push_back(TxD);
          if (idx >= 1 && idx <= 8) rx_byte[idx-1] = TxD;
          if (idx == 9) begin
            rx_q.push_back(rx_byte);
            rx_active = 1'b0;
          end
        end
      end else if (TxD == 1'b0) begin
        rx_active = 1'b1;
        rx_tick   = 0;
        start_ticks.push_back(tick_num);
      end
    end
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_bits.delete();
    start_ticks.delete();
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    rx_update();
    chk("txd", TxD, m_txd());
    chk("ready", ready, m_q.size() < DEPTH);
    chk("busy", busy, m_active || m_q.size() > 0);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic tick);
    TxD_start     = 1'b1;
    TxD_data      = b;
    uart_tick_16x = tick;
    cycle();
    TxD_start     = 1'b0;
    uart_tick_16x = 1'b0;
  endtask

  task automatic run_until_idle(input int period, input int bound);
    int n;
    n = 0;
    TxD_start = 1'b0;
    do begin
      uart_tick_16x = (n % period == 0);
      cycle();
      n++;
    end while (busy && n < bound);
    uart_tick_16x = 1'b0;
    chk("drain_done", busy, 0);
  endtask

  task automatic chk_rx(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) chk({name, "_byte"}, rx_q[i], exp[i]);
  endtask

  initial begin
    int a5_seq[10];
    int low;
    int n;
    int tp;
    logic [7:0] exp_bytes[$];

    a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    vt[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};

    reset         = 1'b1;
    TxD_start     = 1'b0;
    TxD_data      = 8'h00;
    uart_tick_16x = 1'b0;
    cycle();
    cycle();
    chk("rst_txd", TxD, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // idle with ticks running
    for (int i = 0; i < 2000; i++) begin
      uart_tick_16x = (i % 2 == 0);
      cycle();
    end
    uart_tick_16x = 1'b0;
    chk("idle_txd", TxD, 1);
    chk("idle_busy", busy, 0);

    // single byte 0xA5
    rx_clear();
    push_byte(8'hA5, 1'b0);
    run_until_idle(3, 2000);
    exp_bytes = '{8'hA5};
    chk_rx("a5", exp_bytes);
    chk("a5_nbits", rx_bits.size(), 10);
    if (rx_bits.size() >= 10)
      for (int i = 0; i < 10; i++) chk("a5_bit", rx_bits[i], a5_seq[i]);

    // burst of five into a four-entry FIFO
    rx_clear();
    for (int i = 0; i < 6; i++) begin
      TxD_start     = vt[i].start;
      TxD_data      = vt[i].data;
      uart_tick_16x = vt[i].tick;
      cycle();
      chk("vec_txd", TxD, vt[i].exp_txd);
      chk("vec_ready", ready, vt[i].exp_ready);
      chk("vec_busy", busy, vt[i].exp_busy);
    end
    run_until_idle(2, 4000);
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk_rx("burst", exp_bytes);
    for (int i = 1; i < start_ticks.size(); i++)
      chk("burst_spacing", start_ticks[i] - start_ticks[i-1], 161);

    // push while full on the pop tick
    rx_clear();
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b0);
    chk("full_ready", ready, 0);
    push_byte(8'h77, 1'b1);
    chk("fullpop_ready", ready, 1);
    chk("fullpop_txd", TxD, 0);
    push_byte(8'h88, 1'b0);
    chk("fullpop_count3", ready, 0);
    run_until_idle(1, 3000);
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h88};
    chk_rx("fullpop", exp_bytes);

    // reset during BIT_3 of 0x00 with another byte queued
    rx_clear();
    push_byte(8'h00, 1'b0);
    push_byte(8'h5A, 1'b0);
    n = 0;
    do begin
      uart_tick_16x = (n % 2 == 0);
      cycle();
      n++;
    end while (!(rx_active && rx_tick >= 68) && n < 1000);
    chk("bit3_reached", rx_active && rx_tick >= 68 && rx_tick < 80, 1);
    uart_tick_16x = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_txd", TxD, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 1);
    cycle();
    reset = 1'b0;
    rx_clear();
    push_byte(8'h3C, 1'b0);
    run_until_idle(2, 2000);
    exp_bytes = '{8'h3C};
    chk_rx("after_rst", exp_bytes);

    // tick held permanently high
    rx_clear();
    push_byte(8'hFF, 1'b1);
    uart_tick_16x = 1'b1;
    low = 0;
    n = 0;
    do begin
      cycle();
      if (TxD == 1'b0) low++;
      n++;
    end while (busy && n < 400);
    uart_tick_16x = 1'b0;
    chk("tied_done", busy, 0);
    chk("tied_low_cycles", low, 16);
    exp_bytes = '{8'hFF};
    chk_rx("tied", exp_bytes);

    // random traffic with varying tick spacing
    rx_clear();
    m_sent.delete();
    for (int blk = 0; blk < 10; blk++) begin
      tp = $urandom_range(1, 4);
      for (int i = 0; i < 2000; i++) begin
        TxD_start     = ($urandom_range(0, 6) == 0);
        TxD_data      = 8'($urandom);
        uart_tick_16x = ($urandom_range(1, tp) == 1);
        cycle();
      end
    end
    run_until_idle(1, 4000);
    chk_rx("random", m_sent);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
